// File: rtl/exe_pkg.sv
// exe_pkg: shared opcode encoding and widths for the execution unit and its result FIFO
package exe_pkg;
  localparam int OPER_W = 4;
  typedef enum logic [OPER_W-1:0] {
    ADD = 4'd0, OR, NOR, ASR, LSR, U2U1, SMU2, CRC3, CRC4, CNT0, THERM, ONEHOT = 4'd11
  } exe_op_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: generic storage with count-derived full/empty and wrapping pointers
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_req,
  input  logic          pop_req,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push, pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push = push_req & ~full;
  assign pop = pop_req & ~empty;
  assign dout = mem[rp];
  // storage is cleared too so data outputs read zero out of reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/exe_result_fifo.sv
// exe_result_fifo: buffers ALU result tuples for a stalling consumer, counts vf events, flags drops
module exe_result_fifo
  import exe_pkg::*;
#(
  parameter int M = 9,
  parameter int N = OPER_W,
  parameter int DEPTH = 4,
  parameter int CNTW = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clr,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [N-1:0]    i_oper,
  input  logic [M-1:0]    i_result,
  input  logic            i_vf,
  input  logic            i_pf,
  input  logic            i_nf,
  input  logic            i_of,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [N-1:0]    o_oper,
  output logic [M-1:0]    o_result,
  output logic            o_vf,
  output logic            o_pf,
  output logic            o_nf,
  output logic            o_of,
  output logic [CW-1:0]   o_count,
  output logic [CNTW-1:0] o_vf_cnt,
  output logic            o_drop
);
  typedef struct packed {
    logic [N-1:0] oper;
    logic [M-1:0] result;
    logic vf, pf, nf, of;
  } exe_res_t;
  exe_res_t din, dout;
  logic full, empty, push;
  assign din = '{oper: i_oper, result: i_result, vf: i_vf, pf: i_pf, nf: i_nf, of: i_of};
  assign o_ready = ~full;
  assign o_valid = ~empty;
  assign push = i_valid & ~full;
  assign {o_oper, o_result, o_vf, o_pf, o_nf, o_of} = dout;
  sync_fifo #(.W($bits(exe_res_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(i_clk), .rst(i_rst), .push_req(i_valid), .pop_req(i_ready),
    .din(din), .dout(dout), .count(o_count), .full(full), .empty(empty)
  );
  // clear wins over both the vf increment and a same-cycle drop
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_vf_cnt <= '0;
      o_drop <= 1'b0;
    end else if (i_clr) begin
      o_vf_cnt <= '0;
      o_drop <= 1'b0;
    end else begin
      if (push && i_vf && !(&o_vf_cnt)) o_vf_cnt <= o_vf_cnt + 1'b1;
      if (i_valid && full) o_drop <= 1'b1;
    end
endmodule

// File: tb/tb_exe_result_fifo.sv
// tb_exe_result_fifo: directed stimulus with a scoreboard queue checked by a decoupled monitor
module tb_exe_result_fifo;
  logic clk = 0, rst = 1, clr = 0, i_valid = 0, i_ready = 0;
  logic [3:0] i_oper = 0, o_oper;
  logic [8:0] i_result = 0, o_result;
  logic i_vf = 0, i_pf = 0, i_nf = 0, i_of = 0;
  logic o_ready, o_valid, o_vf, o_pf, o_nf, o_of, o_drop;
  logic [2:0] o_count;
  logic [7:0] o_vf_cnt;
  logic [16:0] q[$];
  int errors = 0, checks = 0;

  exe_result_fifo #(.M(9), .N(4), .DEPTH(4), .CNTW(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(i_valid), .o_ready(o_ready),
    .i_oper(i_oper), .i_result(i_result), .i_vf(i_vf), .i_pf(i_pf), .i_nf(i_nf), .i_of(i_of),
    .o_valid(o_valid), .i_ready(i_ready), .o_oper(o_oper), .o_result(o_result),
    .o_vf(o_vf), .o_pf(o_pf), .o_nf(o_nf), .o_of(o_of),
    .o_count(o_count), .o_vf_cnt(o_vf_cnt), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // called at posedge+1; leaves the bench at the following posedge+1
  task automatic drive(input logic v, input logic [3:0] op, input logic [8:0] res,
                       input logic [3:0] flags, input logic rdy, input logic c);
    i_valid = v; i_oper = op; i_result = res;
    {i_vf, i_pf, i_nf, i_of} = flags;
    i_ready = rdy; clr = c;
    @(negedge clk);
    if (v && o_ready) q.push_back({op, res, flags});
    @(posedge clk); #1;
    i_valid = 0; clr = 0;
  endtask

  task automatic idle(input logic rdy);
    drive(0, 4'd0, 9'd0, 4'd0, rdy, 0);
  endtask

  // monitor: every handshake that will complete on the next edge must match the queue head
  initial forever begin
    @(negedge clk);
    if (!rst && o_valid && i_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL head_unexpected: got %0h expected no entry", {o_oper, o_result, o_vf, o_pf, o_nf, o_of});
      end else begin
        logic [16:0] exp;
        exp = q.pop_front();
        if ({o_oper, o_result, o_vf, o_pf, o_nf, o_of} !== exp) begin
          errors++;
          $display("FAIL head_data: got %0h expected %0h", {o_oper, o_result, o_vf, o_pf, o_nf, o_of}, exp);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_count", o_count, 0);
    chk("rst_vf_cnt", o_vf_cnt, 0);
    chk("rst_drop", o_drop, 0);
    chk("rst_result", o_result, 0);
    // 1: single entry, 1-cycle latency
    drive(1, 4'd0, 9'h005, 4'b0000, 0, 0);
    chk("t1_valid", o_valid, 1);
    chk("t1_result", o_result, 9'h005);
    chk("t1_count", o_count, 1);
    idle(1);
    chk("t1_empty_valid", o_valid, 0);
    chk("t1_empty_count", o_count, 0);
    // 2: fill, overflow offer, drain in order
    for (int i = 1; i <= 4; i++) drive(1, 4'(i + 8), 9'(i), 4'b0000, 0, 0);
    chk("t2_ready", o_ready, 0);
    chk("t2_count", o_count, 4);
    chk("t2_drop_before", o_drop, 0);
    drive(1, 4'd15, 9'd5, 4'b0000, 0, 0);
    chk("t2_drop", o_drop, 1);
    chk("t2_count_full", o_count, 4);
    repeat (4) idle(1);
    chk("t2_drained", o_count, 0);
    chk("t2_queue", q.size(), 0);
    // 3: steady push+pop across pointer wrap
    drive(1, 4'd1, 9'd10, 4'b0100, 0, 0);
    drive(1, 4'd2, 9'd11, 4'b0010, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 4'(i), 9'(12 + i), 4'(i), 1, 0);
      chk("t3_count", o_count, 2);
    end
    repeat (2) idle(1);
    chk("t3_drained", o_count, 0);
    // 4: vf counter saturates, clear resets counter and drop
    for (int i = 0; i < 300; i++) drive(1, 4'd3, 9'(i), 4'b1000, 1, 0);
    idle(1);
    chk("t4_vf_sat", o_vf_cnt, 8'hFF);
    chk("t4_drop_kept", o_drop, 1);
    idle(0);
    drive(0, 4'd0, 9'd0, 4'd0, 0, 1);
    chk("t4_clr_vf", o_vf_cnt, 0);
    chk("t4_clr_drop", o_drop, 0);
    // 5: asynchronous reset between edges discards entries
    for (int i = 0; i < 3; i++) drive(1, 4'd4, 9'(i + 40), 4'b0000, 0, 0);
    chk("t5_count3", o_count, 3);
    #2 rst = 1;
    #1;
    chk("t5_async_valid", o_valid, 0);
    chk("t5_async_count", o_count, 0);
    chk("t5_async_ready", o_ready, 1);
    q.delete();
    @(negedge clk); #1 rst = 0;
    @(posedge clk); #1;
    drive(1, 4'd12, 9'h1FF, 4'b0001, 0, 0);
    chk("t5_result", o_result, 9'h1FF);
    chk("t5_of", o_of, 1);
    chk("t5_oper", o_oper, 12);
    // 6: clear beats a same-cycle vf push, which is still stored
    drive(1, 4'd13, 9'h0AA, 4'b1000, 0, 0);
    chk("t6_vf_one", o_vf_cnt, 1);
    chk("t6_count2", o_count, 2);
    drive(1, 4'd14, 9'h055, 4'b1000, 0, 1);
    chk("t6_vf_clr", o_vf_cnt, 0);
    chk("t6_count3", o_count, 3);
    repeat (3) idle(1);
    chk("t6_drained", o_count, 0);
    chk("t6_queue", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
